climate_ctrl_multi: RTL and testbench

Parametrised multi-zone successor to the single-zone cold-storage logic controller. It polls N_CH sensor channels round-robin over a shared request/ready sensor bus and keeps per-channel thresholds. It drives per-channel fan/humidifier outputs with hysteresis, and supports a per-channel manual override. It flags sensor timeouts and streams one report per channel per sweep to the UART TX path over a valid/ready handshake.

---
 rtl/climate_ctrl_multi_if.sv | 43 ++++
 rtl/climate_ctrl_multi.sv | 245 ++++++++++++++++++++++++
 tb/tb_climate_ctrl_multi.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/climate_ctrl_multi_if.sv
// Sensor, command and report bus bundle for the multi-zone climate controller.
// The master modport is the controller side; the slave modport is the
// sensor mux / UART side.
interface climate_ctrl_multi_if #(
    parameter int CHW = 2,
    parameter int DW  = 8
);
    // sensor request/ready bus
    logic           sns_req;
    logic [CHW-1:0] sns_ch;
    logic           sns_ready;
    logic [DW-1:0]  sns_temp;
    logic [DW-1:0]  sns_hum;

    // command strobe from the UART RX parser
    logic           cmd_valid;
    logic [7:0]     cmd_op;
    logic [CHW-1:0] cmd_ch;
    logic [DW-1:0]  cmd_val;

    // report stream towards the UART TX path
    logic           rpt_valid;
    logic           rpt_ready;
    logic [CHW-1:0] rpt_ch;
    logic [DW-1:0]  rpt_temp;
    logic [DW-1:0]  rpt_hum;

    modport master (
        output sns_req, sns_ch,
        input  sns_ready, sns_temp, sns_hum,
        input  cmd_valid, cmd_op, cmd_ch, cmd_val,
        output rpt_valid, rpt_ch, rpt_temp, rpt_hum,
        input  rpt_ready
    );

    modport slave (
        input  sns_req, sns_ch,
        output sns_ready, sns_temp, sns_hum,
        output cmd_valid, cmd_op, cmd_ch, cmd_val,
        input  rpt_valid, rpt_ch, rpt_temp, rpt_hum,
        output rpt_ready
    );
endinterface

// File: rtl/climate_ctrl_multi.sv
// Multi-zone climate controller: round-robin sensor polling, per-channel
// fan/humidifier hysteresis control with manual override, sensor timeout
// alarms and one report per channel per sweep.
module climate_ctrl_multi #(
    parameter int N_CH        = 4,
    parameter int CHW         = 2,
    parameter int DW          = 8,
    parameter int POLL_CYCLES = 1_000_000,
    parameter int TIMEOUT     = 50_000,
    parameter int DEF_THI     = 18,
    parameter int DEF_HLO     = 10,
    parameter int DEF_HYST    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    climate_ctrl_multi_if.master io,
    output logic [N_CH-1:0]      fan,
    output logic [N_CH-1:0]      hum_on,
    output logic [N_CH-1:0]      manual,
    output logic [N_CH-1:0]      alarm
);

    localparam int PC_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // index width that exactly addresses the per-channel vectors/arrays
    localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [7:0] OP_THI  = 8'h41; // 'A'
    localparam logic [7:0] OP_HLO  = 8'h44; // 'D'
    localparam logic [7:0] OP_HYST = 8'h48; // 'H'
    localparam logic [7:0] OP_MAN  = 8'h4D; // 'M'
    localparam logic [7:0] OP_AUTO = 8'h52; // 'R'

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EVAL,
        S_REPORT,
        S_NEXT
    } state_t;

    state_t          state, state_nx;
    logic [CHW-1:0]  ch;
    logic [IW-1:0]   chi;
    logic [PC_W-1:0] pcnt;
    logic [TO_W-1:0] tcnt;

    logic [DW-1:0]   thri [N_CH];
    logic [DW-1:0]   hlo  [N_CH];
    logic [DW-1:0]   hyst;

    // samples captured on sns_ready, consumed by EVAL
    logic [DW-1:0]   smp_temp_p0, smp_hum_p0;
    // report fields, loaded in EVAL and held through REPORT
    logic [CHW-1:0]  rpt_ch_p1;
    logic [DW-1:0]   rpt_temp_p1, rpt_hum_p1;

    logic            pcnt_top, tcnt_top, last_ch;
    logic            sweep_start, smp_take, to_hit, eval_en, ch_step;
    logic            sns_req_c, rpt_valid_c;
    logic [DW-1:0]   thr_lo, hum_hi;
    logic            fan_ev, hum_ev;
    logic            cmd_ok;
    logic [IW-1:0]   cmd_chi;

    // thri - hyst at DW+1 bits, clamped at zero
    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[DW] ? '0 : d[DW-1:0];
    endfunction

    // hlo + hyst at DW+1 bits, clamped at full scale
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW] ? '1 : s[DW-1:0];
    endfunction

    assign chi      = ch[IW-1:0];
    assign cmd_chi  = io.cmd_ch[IW-1:0];
    assign cmd_ok   = io.cmd_valid && (32'(io.cmd_ch) < N_CH);
    assign pcnt_top = (pcnt == PC_W'(POLL_CYCLES - 1));
    assign tcnt_top = (tcnt == TO_W'(TIMEOUT - 1));
    assign last_ch  = (ch == CHW'(N_CH - 1));

    assign thr_lo   = sat_sub(thri[chi], hyst);
    assign hum_hi   = sat_add(hlo[chi], hyst);
    assign fan_ev   = (smp_temp_p0 > thri[chi]) ? 1'b1 :
                      (smp_temp_p0 <= thr_lo)   ? 1'b0 : fan[chi];
    assign hum_ev   = (smp_hum_p0 < hlo[chi])   ? 1'b1 :
                      (smp_hum_p0 >= hum_hi)    ? 1'b0 : hum_on[chi];

    assign io.sns_req   = sns_req_c;
    assign io.sns_ch    = ch;
    assign io.rpt_valid = rpt_valid_c;
    assign io.rpt_ch    = rpt_ch_p1;
    assign io.rpt_temp  = rpt_temp_p1;
    assign io.rpt_hum   = rpt_hum_p1;

    // FSM state register; reset aborts any sweep in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next-state decode plus the request/valid levels and per-state strobes
    always_comb begin
        state_nx    = state;
        sns_req_c   = 1'b0;
        rpt_valid_c = 1'b0;
        sweep_start = 1'b0;
        smp_take    = 1'b0;
        to_hit      = 1'b0;
        eval_en     = 1'b0;
        ch_step     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pcnt_top) begin
                    sweep_start = 1'b1;
                    state_nx    = S_REQ;
                end
            end
            S_REQ: begin
                sns_req_c = 1'b1;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                sns_req_c = 1'b1;
                if (io.sns_ready) begin
                    smp_take = 1'b1;
                    state_nx = S_EVAL;
                end else if (tcnt_top) begin
                    to_hit   = 1'b1;
                    state_nx = S_NEXT;
                end
            end
            S_EVAL: begin
                eval_en  = 1'b1;
                state_nx = S_REPORT;
            end
            S_REPORT: begin
                rpt_valid_c = 1'b1;
                if (io.rpt_ready) state_nx = S_NEXT;
            end
            S_NEXT: begin
                if (last_ch) begin
                    state_nx = S_IDLE;
                end else begin
                    ch_step  = 1'b1;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // period counter: free-running, saturating, cleared when a sweep starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pcnt <= '0;
        else if (sweep_start)  pcnt <= '0;
        else if (!pcnt_top)    pcnt <= pcnt + 1'b1;
    end

    // channel pointer for the current sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ch <= '0;
        else if (sweep_start) ch <= '0;
        else if (ch_step)     ch <= ch + 1'b1;
    end

    // sensor response timer, restarted on every request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                tcnt <= '0;
        else if (state == S_REQ)   tcnt <= '0;
        else if (state == S_WAIT)  tcnt <= tcnt + 1'b1;
    end

    // ---- stage p0: sample capture on sns_ready ----
    always_ff @(posedge clk) begin
        if (smp_take) begin
            smp_temp_p0 <= io.sns_temp;
            smp_hum_p0  <= io.sns_hum;
        end
    end

    // ---- stage p1: report fields, frozen until the report is accepted ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_ch_p1   <= '0;
            rpt_temp_p1 <= '0;
            rpt_hum_p1  <= '0;
        end else if (eval_en) begin
            rpt_ch_p1   <= ch;
            rpt_temp_p1 <= smp_temp_p0;
            rpt_hum_p1  <= smp_hum_p0;
        end
    end

    // alarm tracks the outcome of the most recent read of each channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        alarm      <= '0;
        else if (smp_take) alarm[chi] <= 1'b0;
        else if (to_hit)   alarm[chi] <= 1'b1;
    end

    // thresholds, hysteresis, override and actuator outputs; a command
    // landing in the same cycle as EVAL is ordered after it so 'M' wins
    // and threshold writes only affect later evaluations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fan    <= '0;
            hum_on <= '0;
            manual <= '0;
            hyst   <= DW'(DEF_HYST);
            for (int i = 0; i < N_CH; i++) begin
                thri[i] <= DW'(DEF_THI);
                hlo[i]  <= DW'(DEF_HLO);
            end
        end else begin
            if (eval_en && !manual[chi]) begin
                fan[chi]    <= fan_ev;
                hum_on[chi] <= hum_ev;
            end
            if (io.cmd_valid) begin
                case (io.cmd_op)
                    OP_THI:  if (cmd_ok) thri[cmd_chi] <= io.cmd_val;
                    OP_HLO:  if (cmd_ok) hlo[cmd_chi]  <= io.cmd_val;
                    OP_HYST: hyst <= io.cmd_val;
                    OP_MAN: begin
                        if (cmd_ok) begin
                            manual[cmd_chi] <= 1'b1;
                            fan[cmd_chi]    <= io.cmd_val[0];
                            hum_on[cmd_chi] <= io.cmd_val[1];
                        end
                    end
                    OP_AUTO: if (cmd_ok) manual[cmd_chi] <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_climate_ctrl_multi.sv
// Directed bench for climate_ctrl_multi: sweeps, hysteresis, timeout,
// manual override, report backpressure and asynchronous reset.
module tb_climate_ctrl_multi;

    localparam int N_CH     = 4;
    localparam int CHW      = 3;
    localparam int DW       = 8;
    localparam int POLL     = 200;
    localparam int TMO      = 40;
    localparam int RESP_DLY = 10;

    typedef struct {
        int ch;
        int temp;
        int hum;
    } rpt_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] fan, hum_on, manual, alarm;

    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   sweep_cnt = 0;
    int   last_acc  = 0;
    int   temp_tbl [8];
    int   hum_tbl  [8];
    bit   silent   [8];
    int   req_len  [8];
    int   start_q  [$];
    int   ch_q     [$];
    rpt_t rpt_q    [$];

    climate_ctrl_multi_if #(.CHW(CHW), .DW(DW)) sif ();

    climate_ctrl_multi #(
        .N_CH(N_CH), .CHW(CHW), .DW(DW), .POLL_CYCLES(POLL), .TIMEOUT(TMO),
        .DEF_THI(18), .DEF_HLO(10), .DEF_HYST(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io     (sif.master),
        .fan    (fan),
        .hum_on (hum_on),
        .manual (manual),
        .alarm  (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] op, input int c, input int v);
        @(negedge clk);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = op;
        sif.cmd_ch    = CHW'(c);
        sif.cmd_val   = DW'(v);
        @(negedge clk);
        sif.cmd_valid = 1'b0;
        #2;
    endtask

    // wait for the next sweep to start, then long enough for it to finish
    task automatic wait_sweep();
        int target;
        int k;
        target = sweep_cnt + 1;
        k = 0;
        while (sweep_cnt < target && k < 1000) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("sweep_start", sweep_cnt >= target, 1);
        repeat (150) @(negedge clk);
        #2;
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // sensor model: answers RESP_DLY cycles into a request unless silenced
    initial begin
        int wcnt;
        wcnt = 0;
        sif.sns_ready = 1'b0;
        sif.sns_temp  = '0;
        sif.sns_hum   = '0;
        forever begin
            @(negedge clk);
            sif.sns_ready = 1'b0;
            if (sif.sns_req && !silent[sif.sns_ch]) begin
                wcnt++;
                if (wcnt == RESP_DLY) begin
                    sif.sns_ready = 1'b1;
                    sif.sns_temp  = DW'(temp_tbl[sif.sns_ch]);
                    sif.sns_hum   = DW'(hum_tbl[sif.sns_ch]);
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // bus monitor: request edges, sweep starts and accepted reports
    initial begin
        logic prev_req;
        int   len;
        int   rch;
        prev_req = 1'b0;
        len = 0;
        rch = 0;
        forever begin
            @(negedge clk);
            #1;
            if (sif.sns_req && !prev_req) begin
                rch = int'(sif.sns_ch);
                len = 0;
                ch_q.push_back(rch);
                if (rch == 0) begin
                    sweep_cnt++;
                    start_q.push_back(cyc);
                end
            end
            if (sif.sns_req) len++;
            if (!sif.sns_req && prev_req) req_len[rch] = len;
            if (sif.rpt_valid && sif.rpt_ready) begin
                rpt_q.push_back('{int'(sif.rpt_ch), int'(sif.rpt_temp), int'(sif.rpt_hum)});
                last_acc = cyc;
            end
            prev_req = sif.sns_req;
        end
    end

    // watchdog
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int viol;
        int sb;
        int exp_ch [3];
        logic [CHW-1:0] c0;
        logic [DW-1:0]  t0, h0;

        sif.cmd_valid = 1'b0;
        sif.cmd_op    = '0;
        sif.cmd_ch    = '0;
        sif.cmd_val   = '0;
        sif.rpt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            temp_tbl[i] = 20;
            hum_tbl[i]  = 30;
            silent[i]   = 1'b0;
            req_len[i]  = 0;
        end

        // reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req", sif.sns_req, 0);
        chk("rst_ch", sif.sns_ch, 0);
        chk("rst_rvld", sif.rpt_valid, 0);
        chk("rst_rfields", {sif.rpt_ch, sif.rpt_temp, sif.rpt_hum}, 0);
        chk("rst_outs", {fan, hum_on, manual, alarm}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // sweep 1: all channels hot and humid
        wait_sweep();
        chk("s1_fan", fan, 4'b1111);
        chk("s1_hum", hum_on, 4'b0000);
        chk("s1_nch", ch_q.size(), 4);
        for (int i = 0; i < 4 && i < ch_q.size(); i++) chk("s1_chseq", ch_q[i], i);
        chk("s1_nrpt", rpt_q.size(), 4);
        for (int i = 0; i < rpt_q.size(); i++) begin
            chk("s1_rpt_ch", rpt_q[i].ch, i);
            chk("s1_rpt_t", rpt_q[i].temp, 20);
            chk("s1_rpt_h", rpt_q[i].hum, 30);
        end

        // hysteresis on ch0: temp 19,17,16,15 / hum 9,11,12,12
        temp_tbl[0] = 19; hum_tbl[0] = 9;
        wait_sweep();
        chk("period", start_q[1] - start_q[0], POLL);
        chk("hy19_fan", fan, 4'b1111);
        chk("hy9_hum", hum_on, 4'b0001);
        temp_tbl[0] = 17; hum_tbl[0] = 11;
        wait_sweep();
        chk("hy17_fan", fan, 4'b1111);
        chk("hy11_hum", hum_on, 4'b0001);
        temp_tbl[0] = 16; hum_tbl[0] = 12;
        wait_sweep();
        chk("hy16_fan", fan, 4'b1110);
        chk("hy12_hum", hum_on, 4'b0000);
        temp_tbl[0] = 15;
        wait_sweep();
        chk("hy15_fan", fan, 4'b1110);

        // ch2 silent
        silent[2] = 1'b1;
        rpt_q.delete();
        ch_q.delete();
        wait_sweep();
        chk("to_alarm", alarm, 4'b0100);
        chk("to_fan", fan, 4'b1110);
        chk("to_len", (req_len[2] >= TMO) && (req_len[2] <= TMO + 1), 1);
        chk("to_nch", ch_q.size(), 4);
        if (ch_q.size() == 4) chk("to_ch3_polled", ch_q[3], 3);
        chk("to_nrpt", rpt_q.size(), 3);
        exp_ch = '{0, 1, 3};
        for (int i = 0; i < 3 && i < rpt_q.size(); i++) chk("to_rpt_ch", rpt_q[i].ch, exp_ch[i]);

        // ch2 recovers
        silent[2] = 1'b0;
        rpt_q.delete();
        wait_sweep();
        chk("rec_alarm", alarm, 4'b0000);
        chk("rec_nrpt", rpt_q.size(), 4);

        // manual override on ch1
        send_cmd(8'h4D, 1, 2);
        chk("man_fan", fan, 4'b1100);
        chk("man_hum", hum_on, 4'b0010);
        chk("man_flag", manual, 4'b0010);
        temp_tbl[1] = 30;
        rpt_q.delete();
        wait_sweep();
        chk("man_fan_hold", fan, 4'b1100);
        chk("man_hum_hold", hum_on, 4'b0010);
        chk("man_nrpt", rpt_q.size(), 4);
        if (rpt_q.size() > 1) chk("man_rpt_t", rpt_q[1].temp, 30);
        send_cmd(8'h52, 1, 0);
        chk("auto_flag", manual, 4'b0000);
        chk("auto_fan_hold", fan, 4'b1100);
        wait_sweep();
        chk("auto_fan", fan, 4'b1110);
        chk("auto_hum", hum_on, 4'b0000);
        send_cmd(8'h4D, 5, 3);
        chk("badch_man", manual, 4'b0000);
        chk("badch_outs", {fan, hum_on}, 8'b1110_0000);

        // report backpressure
        sif.rpt_ready = 1'b0;
        k = 0;
        while (!sif.rpt_valid && k < 400) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("bp_valid", sif.rpt_valid, 1);
        chk("bp_ch", sif.rpt_ch, 0);
        chk("bp_temp", sif.rpt_temp, 15);
        chk("bp_hum", sif.rpt_hum, 12);
        c0 = sif.rpt_ch; t0 = sif.rpt_temp; h0 = sif.rpt_hum;
        viol = 0;
        repeat (500) begin
            @(negedge clk);
            #2;
            if (!sif.rpt_valid || sif.sns_req || sif.rpt_ch !== c0 ||
                sif.rpt_temp !== t0 || sif.rpt_hum !== h0) viol++;
        end
        chk("bp_stable", viol, 0);
        sb = sweep_cnt;
        @(negedge clk);
        sif.rpt_ready = 1'b1;
        k = 0;
        while (sweep_cnt == sb && k < 400) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("bp_restart", sweep_cnt > sb, 1);
        chk("bp_gap", start_q[start_q.size() - 1] - last_acc, 3);
        repeat (150) @(negedge clk);
        #2;

        // reset mid-WAIT, thresholds must return to defaults
        send_cmd(8'h41, 0, 25);
        temp_tbl[0] = 19; hum_tbl[0] = 10;
        temp_tbl[1] = 18; hum_tbl[1] = 10;
        temp_tbl[2] = 19; hum_tbl[2] = 10;
        temp_tbl[3] = 19; hum_tbl[3] = 9;
        k = 0;
        while (!(sif.sns_req && sif.sns_ch == 0) && k < 400) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("rw_req", sif.sns_req, 1);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rw_req_drop", sif.sns_req, 0);
        chk("rw_rvld", sif.rpt_valid, 0);
        chk("rw_outs", {fan, hum_on, manual, alarm}, 0);
        chk("rw_ch", sif.sns_ch, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_sweep();
        chk("def_fan", fan, 4'b1101);
        chk("def_hum", hum_on, 4'b1000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
